// File: rtl/systolic_seq_ctrl.sv
// Control sequencer for an N x N systolic PE array (WS and OS jobs).
// Optional busy-cycle counter enabled by SYSTOLIC_SEQ_PERF_EN.
module systolic_seq_ctrl #(
    parameter int N     = 4,
    parameter int CNT_W = 9,
    parameter int RW    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [CNT_W-1:0] k_len,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             output_stationary,
    output logic             preload_valid,
    output logic [RW-1:0]    preload_row,
    output logic             pe_clear,
    output logic [N-1:0]     feed_en,
    output logic [CNT_W-1:0] feed_step,
    output logic [RW-1:0]    drain_row,
    output logic             res_valid,
    output logic [31:0]      perf_cycles
);

    localparam int SW = CNT_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRELOAD,
        S_CLEAR,
        S_COMPUTE,
        S_FLUSH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [SW-1:0]    cnt, cnt_nxt;
    logic [SW-1:0]    comp_last;
    logic             mode_q;
    logic [CNT_W-1:0] k_q;
    logic             err_q;
    logic             accept;
    logic             reject;
    logic             row_last;

    assign accept   = (state == S_IDLE) && start && !abort && (k_len != '0);
    assign reject   = (state == S_IDLE) && start && !abort && (k_len == '0);
    assign row_last = (cnt == SW'(N - 1));
    // widened so k_len + N - 2 never wraps for the largest k_len
    assign comp_last = SW'(k_q) + SW'(N - 2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q <= 1'b0;
            k_q    <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= reject;
            if (accept) begin
                mode_q <= mode;
                k_q    <= k_len;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + SW'(1);
        unique case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (accept) begin
                    state_nxt = mode ? S_CLEAR : S_PRELOAD;
                end
            end
            S_PRELOAD: begin
                if (row_last) begin
                    state_nxt = S_COMPUTE;
                    cnt_nxt   = '0;
                end
            end
            S_CLEAR: begin
                state_nxt = S_COMPUTE;
                cnt_nxt   = '0;
            end
            S_COMPUTE: begin
                if (cnt == comp_last) begin
                    state_nxt = S_FLUSH;
                    cnt_nxt   = '0;
                end
            end
            S_FLUSH: begin
                if (row_last) begin
                    state_nxt = mode_q ? S_DRAIN : S_DONE;
                    cnt_nxt   = '0;
                end
            end
            S_DRAIN: begin
                if (row_last) begin
                    state_nxt = S_DONE;
                    cnt_nxt   = '0;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
        // abort overrides every transition out of a busy state
        if (abort && (state != S_IDLE)) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
        end
    end

    always_comb begin
        busy              = (state != S_IDLE);
        done              = (state == S_DONE);
        err               = err_q;
        output_stationary = busy && mode_q;
        preload_valid     = 1'b0;
        preload_row       = '0;
        pe_clear          = 1'b0;
        feed_en           = '0;
        feed_step         = '0;
        drain_row         = '0;
        res_valid         = 1'b0;
        unique case (state)
            S_PRELOAD: begin
                preload_valid = 1'b1;
                preload_row   = cnt[RW-1:0];
            end
            S_CLEAR: begin
                pe_clear = 1'b1;
            end
            S_COMPUTE: begin
                feed_step = cnt[CNT_W-1:0];
                for (int r = 0; r < N; r++) begin
                    feed_en[r] = (cnt >= SW'(r)) &&
                                 (cnt < SW'(r) + SW'(k_q));
                end
            end
            S_FLUSH: begin
                if (!mode_q) begin
                    res_valid = 1'b1;
                    drain_row = cnt[RW-1:0];
                end
            end
            S_DRAIN: begin
                preload_valid = 1'b1;
                res_valid     = 1'b1;
                drain_row     = cnt[RW-1:0];
            end
            default: begin
            end
        endcase
    end

`ifdef SYSTOLIC_SEQ_PERF_EN
    logic [31:0] perf_cnt;
    logic [31:0] perf_inc;

    assign perf_inc = (&perf_cnt) ? perf_cnt : perf_cnt + 32'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_cnt    <= '0;
            perf_cycles <= '0;
        end else begin
            if (accept) begin
                perf_cnt <= '0;
            end else if (state != S_IDLE) begin
                perf_cnt <= perf_inc;
            end
            // perf_inc includes the DONE cycle itself
            if ((state == S_DONE) && !abort) begin
                perf_cycles <= perf_inc;
            end
        end
    end
`else
    assign perf_cycles = '0;
`endif

endmodule
